// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the sequence controller and the iterative
// signed multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi_res;
  logic [WIDTH-1:0] lo_res;
  logic             mult_div_done;
  logic             busy;
  logic             div_zero;

  modport master (
    output mult_start, div_start, op_a, op_b,
    input  hi_res, lo_res, mult_div_done, busy, div_zero
  );

  modport slave (
    input  mult_start, div_start, op_a, op_b,
    output hi_res, lo_res, mult_div_done, busy, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 shift-add) and restoring divide, one bit
// per cycle, sharing a single 2*WIDTH accumulator.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           CLK,
  input  logic           RST,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sign_q, sign_d;
  logic               rsign_q, rsign_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               dz_q, dz_d;

  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH-1:0]   diff_s;
  logic [2*WIDTH-1:0] step_mul_s;
  logic [2*WIDTH-1:0] step_div_s;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    mag = v[WIDTH-1] ? (-v) : v;
  endfunction

  // One shift-add or restoring-subtract iteration of the accumulator.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    trial_s    = acc_q[2*WIDTH-1:WIDTH-1];
    diff_s     = trial_s[WIDTH-1:0] - b_q;
    step_mul_s = acc_q[0] ? {mul_sum_s, acc_q[WIDTH-1:1]}
                          : {1'b0, acc_q[2*WIDTH-1:1]};
    if (trial_s >= {1'b0, b_q}) begin
      step_div_s = {diff_s, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step_div_s = {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state, datapath load and result write-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    sign_d  = sign_q;
    rsign_d = rsign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mult_start) begin
          state_d = MUL;
          acc_d   = {{WIDTH{1'b0}}, mag(bus.op_a)};
          b_d     = mag(bus.op_b);
          sign_d  = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
          rsign_d = 1'b0;
          cnt_d   = CNT_INIT;
          dz_d    = 1'b0;
          busy_d  = 1'b1;
        end else if (bus.div_start) begin
          if (bus.op_b == {WIDTH{1'b0}}) begin
            state_d = DONE;
            hi_d    = bus.op_a;
            lo_d    = {WIDTH{1'b1}};
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = DIV;
            acc_d   = {{WIDTH{1'b0}}, mag(bus.op_a)};
            b_d     = mag(bus.op_b);
            sign_d  = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
            rsign_d = bus.op_a[WIDTH-1];
            cnt_d   = CNT_INIT;
            dz_d    = 1'b0;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        acc_d = step_mul_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d      = DONE;
          {hi_d, lo_d} = sign_q ? (-step_mul_s) : step_mul_s;
          done_d       = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      DIV: begin
        acc_d = step_div_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
          lo_d    = sign_q  ? (-step_div_s[WIDTH-1:0]) : step_div_s[WIDTH-1:0];
          hi_d    = rsign_q ? (-step_div_s[2*WIDTH-1:WIDTH]) : step_div_s[2*WIDTH-1:WIDTH];
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sign_q  <= 1'b0;
      rsign_q <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      rsign_q <= rsign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.hi_res        = hi_q;
  assign bus.lo_res        = lo_q;
  assign bus.mult_div_done = done_q;
  assign bus.busy          = busy_q;
  assign bus.div_zero      = dz_q;
endmodule
